// File: rtl/frame_sort_pkg.sv
// Shared definitions for the frame sorter: FSM state codes, counter sizing and
// the rule deciding which compare-swap pairs lie inside the current frame.
package frame_sort_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SORT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;

  function automatic int cw_calc(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Pair (idx, idx+1) may only swap when both entries belong to the frame.
  function automatic logic pair_active(input int idx, input int len);
    return (idx + 1) < len;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-swap of two {data, strb} entries, ordered by the data
// field only; equal keys keep their order so the sort stays stable.
module sort_cmp_swap #(
  parameter int DW = 64,
  parameter int SW = 8
) (
  input  logic             en_i,
  input  logic [DW+SW-1:0] a_i,
  input  logic [DW+SW-1:0] b_i,
  output logic [DW+SW-1:0] lo_o,
  output logic [DW+SW-1:0] hi_o
);

  logic swap_s;

  assign swap_s = en_i && (a_i[DW+SW-1:SW] > b_i[DW+SW-1:SW]);
  assign lo_o   = swap_s ? b_i : a_i;
  assign hi_o   = swap_s ? a_i : b_i;

endmodule

// File: rtl/frame_sort_core.sv
// Frame sorter: buffers one last-delimited frame, odd-even transposition sorts it
// in place by unsigned data word, then streams it out to the output FIFO.
module frame_sort_core
  import frame_sort_pkg::*;
#(
  parameter int TRANS_BITS      = 64,
  parameter int TRANS_BYTE_SIZE = 8,
  parameter int DEPTH           = 16,
  parameter int CW              = cw_calc(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TRANS_BITS-1:0]      din_isif_data,
  input  logic [TRANS_BYTE_SIZE-1:0] din_isif_strb,
  input  logic                       din_isif_last,
  input  logic                       din_isif_user,
  input  logic                       din_isif_empty_n,
  output logic                       dout_isif_read,
  output logic [TRANS_BITS-1:0]      dout_osif_data,
  output logic [TRANS_BYTE_SIZE-1:0] dout_osif_strb,
  output logic                       dout_osif_last,
  output logic                       dout_osif_user,
  input  logic                       din_osif_full_n,
  output logic                       dout_osif_write,
  output logic [CW-1:0]              frame_len,
  output logic                       frame_ovf,
  output logic [2:0]                 current_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TRANS_BITS + TRANS_BYTE_SIZE;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(DEPTH - 1);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]    pass_cnt_q, pass_cnt_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]    frame_len_q, frame_len_d;
  logic             frame_ovf_q, frame_ovf_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [EW-1:0]    sort_s [DEPTH];
  logic [EW-1:0]    lo_s [DEPTH-1];
  logic [EW-1:0]    hi_s [DEPTH-1];
  logic [DEPTH-2:0] pair_en_s;
  logic [EW-1:0]    head_s;
  logic             rd_s;
  logic             wr_s;
  logic             last_s;
  logic             unused_s;

  assign unused_s = din_isif_user;

  assign rd_s   = (state_q == ST_LOAD) && din_isif_empty_n;
  assign wr_s   = (state_q == ST_DRAIN) && din_osif_full_n;
  assign head_s = mem_q[rd_cnt_q[AW-1:0]];
  assign last_s = wr_s && (rd_cnt_q == (frame_len_q - CNT_ONE));

  assign dout_isif_read  = rd_s;
  assign dout_osif_write = wr_s;
  assign dout_osif_last  = last_s;
  assign dout_osif_data  = head_s[EW-1:TRANS_BYTE_SIZE];
  assign dout_osif_strb  = head_s[TRANS_BYTE_SIZE-1:0];
  assign dout_osif_user  = 1'b0;
  assign frame_len       = frame_len_q;
  assign frame_ovf       = frame_ovf_q;
  assign current_state   = state_q;

  // Even passes use pairs starting at even indices, odd passes at odd indices.
  for (genvar g = 0; g < DEPTH - 1; g++) begin : g_pair
    assign pair_en_s[g] = (1'(g % 2) == pass_cnt_q[0]) && pair_active(g, 32'(frame_len_q));

    sort_cmp_swap #(
      .DW (TRANS_BITS),
      .SW (TRANS_BYTE_SIZE)
    ) u_cmp (
      .en_i (pair_en_s[g]),
      .a_i  (mem_q[g]),
      .b_i  (mem_q[g + 1]),
      .lo_o (lo_s[g]),
      .hi_o (hi_s[g])
    );
  end

  // Gather one pass: only pairs of the current parity write back, so no entry has two sources.
  always_comb begin
    sort_s = mem_q;
    for (int i = 0; i < DEPTH - 1; i++) begin
      sort_s[i]     = (1'(i % 2) == pass_cnt_q[0]) ? lo_s[i] : sort_s[i];
      sort_s[i + 1] = (1'(i % 2) == pass_cnt_q[0]) ? hi_s[i] : sort_s[i + 1];
    end
  end

  // Next-state logic for the FSM, counters, frame status and buffer.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    frame_len_d = frame_len_q;
    frame_ovf_d = frame_ovf_q;
    mem_d       = mem_q;
    case (state_q)
      ST_IDLE: begin
        wr_cnt_d   = CNT_ZERO;
        pass_cnt_d = CNT_ZERO;
        rd_cnt_d   = CNT_ZERO;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        if (rd_s) begin
          mem_d[wr_cnt_q[AW-1:0]] = {din_isif_data, din_isif_strb};
          wr_cnt_d                = wr_cnt_q + CNT_ONE;
          if (din_isif_last || (wr_cnt_q == CNT_TOP)) begin
            frame_len_d = wr_cnt_q + CNT_ONE;
            state_d     = ST_SORT;
            // A full buffer without last truncates; following beats start a new frame.
            if (!din_isif_last) begin
              frame_ovf_d = 1'b1;
            end else begin
              frame_ovf_d = frame_ovf_q;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_SORT: begin
        mem_d = sort_s;
        if (pass_cnt_q == (frame_len_q - CNT_ONE)) begin
          pass_cnt_d = CNT_ZERO;
          state_d    = ST_DRAIN;
        end else begin
          pass_cnt_d = pass_cnt_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (wr_s) begin
          rd_cnt_d = rd_cnt_q + CNT_ONE;
          if (last_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= CNT_ZERO;
      pass_cnt_q  <= CNT_ZERO;
      rd_cnt_q    <= CNT_ZERO;
      frame_len_q <= CNT_ZERO;
      frame_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_len_q <= frame_len_d;
      frame_ovf_q <= frame_ovf_d;
    end
  end

  // Frame buffer; its contents are meaningless until a frame is loaded.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_frame_sort_core.sv
// Self-checking bench for frame_sort_core: FIFO models on both sides and a
// scoreboard of expected output beats.
module tb_frame_sort_core;
  import frame_sort_pkg::*;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
    logic [63:0] ed;
    logic [7:0]  es;
    logic        el;
    int          fr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] din_isif_data = 64'd0;
  logic [7:0]  din_isif_strb = 8'd0;
  logic        din_isif_last = 1'b0;
  logic        din_isif_user = 1'b0;
  logic        din_isif_empty_n = 1'b0;
  logic        dout_isif_read;
  logic [63:0] dout_osif_data;
  logic [7:0]  dout_osif_strb;
  logic        dout_osif_last;
  logic        dout_osif_user;
  logic        din_osif_full_n = 1'b1;
  logic        dout_osif_write;
  logic [4:0]  frame_len;
  logic        frame_ovf;
  logic [2:0]  current_state;

  beat_t      in_q[$];
  beat_t      exp_q[$];
  logic [2:0] st_log[$];
  vec_t       tbl[13];
  int         stall_in[8] = '{50, 20, 80, 10, 70, 30, 60, 40};
  int         stall_es[8] = '{4, 2, 6, 8, 1, 7, 5, 3};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_rd = -1;
  int first_wr = -1;
  int last_wr = -1;
  int n_wr = 0;
  int stall_at = -1;
  int stall_len = 0;
  int stall_left = 0;

  frame_sort_core dut (
    .clk              (clk),
    .reset            (reset),
    .din_isif_data    (din_isif_data),
    .din_isif_strb    (din_isif_strb),
    .din_isif_last    (din_isif_last),
    .din_isif_user    (din_isif_user),
    .din_isif_empty_n (din_isif_empty_n),
    .dout_isif_read   (dout_isif_read),
    .dout_osif_data   (dout_osif_data),
    .dout_osif_strb   (dout_osif_strb),
    .dout_osif_last   (dout_osif_last),
    .dout_osif_user   (dout_osif_user),
    .din_osif_full_n  (din_osif_full_n),
    .dout_osif_write  (dout_osif_write),
    .frame_len        (frame_len),
    .frame_ovf        (frame_ovf),
    .current_state    (current_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // One clock: drive FIFO heads at negedge, sample 1ns later, act on what the posedge will commit.
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (in_q.size() > 0) begin
      din_isif_data    = in_q[0].d;
      din_isif_strb    = in_q[0].s;
      din_isif_last    = in_q[0].l;
      din_isif_empty_n = 1'b1;
    end else begin
      din_isif_data    = 64'd0;
      din_isif_strb    = 8'd0;
      din_isif_last    = 1'b0;
      din_isif_empty_n = 1'b0;
    end
    din_osif_full_n = (stall_left == 0);
    #1;
    cyc++;
    st_log.push_back(current_state);
    if (dout_isif_read) begin
      if (first_rd < 0) first_rd = cyc;
      if (in_q.size() > 0) void'(in_q.pop_front());
    end
    if (stall_left > 0) begin
      check("stall_write", 64'(dout_osif_write), 64'd0);
      if (exp_q.size() > 0) check("stall_hold", dout_osif_data, exp_q[0].d);
      stall_left--;
    end
    if (dout_osif_write) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      n_wr++;
      if (exp_q.size() == 0) begin
        check("extra_write", 64'(dout_osif_write), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", dout_osif_data, e.d);
        check("out_strb", 64'(dout_osif_strb), 64'(e.s));
        check("out_last", 64'(dout_osif_last), 64'(e.l));
      end
      if (n_wr == stall_at) stall_left = stall_len;
    end else begin
      check("last_no_write", 64'(dout_osif_last), 64'd0);
    end
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check({nm, "_timeout"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int len;
    tbl[0]  = '{64'd40, 8'h04, 1'b0, 64'd10, 8'h01, 1'b0, 0};
    tbl[1]  = '{64'd10, 8'h01, 1'b0, 64'd20, 8'h02, 1'b0, 0};
    tbl[2]  = '{64'd30, 8'h03, 1'b0, 64'd30, 8'h03, 1'b0, 0};
    tbl[3]  = '{64'd20, 8'h02, 1'b1, 64'd40, 8'h04, 1'b1, 0};
    tbl[4]  = '{64'd5,  8'h01, 1'b0, 64'd3,  8'h03, 1'b0, 1};
    tbl[5]  = '{64'd5,  8'h02, 1'b0, 64'd5,  8'h01, 1'b0, 1};
    tbl[6]  = '{64'd3,  8'h03, 1'b1, 64'd5,  8'h02, 1'b1, 1};
    tbl[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h11, 1'b0, 64'd0, 8'h22, 1'b0, 2};
    tbl[8]  = '{64'd0, 8'h22, 1'b0, 64'd1, 8'h55, 1'b0, 2};
    tbl[9]  = '{64'h8000_0000_0000_0000, 8'h33, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 8'h44, 1'b0, 2};
    tbl[10] = '{64'h7FFF_FFFF_FFFF_FFFF, 8'h44, 1'b0, 64'h8000_0000_0000_0000, 8'h33, 1'b0, 2};
    tbl[11] = '{64'd1, 8'h55, 1'b0, 64'h8000_0000_0000_0000, 8'h66, 1'b0, 2};
    tbl[12] = '{64'h8000_0000_0000_0000, 8'h66, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h11, 1'b1, 2};

    // Reset state, with a non-empty input to show read stays low.
    din_isif_empty_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 64'(current_state), 64'(ST_IDLE));
    check("rst_len", 64'(frame_len), 64'd0);
    check("rst_ovf", 64'(frame_ovf), 64'd0);
    check("rst_read", 64'(dout_isif_read), 64'd0);
    check("rst_write", 64'(dout_osif_write), 64'd0);
    check("rst_user", 64'(dout_osif_user), 64'd0);
    din_isif_empty_n = 1'b0;
    reset = 1'b0;
    repeat (2) step();
    check("load_wait", 64'(current_state), 64'(ST_LOAD));

    // Table frames: latency from first read to first write is 2L with no bubbles.
    for (int f = 0; f < 3; f++) begin
      len = 0;
      first_rd = -1;
      first_wr = -1;
      for (int i = 0; i < 13; i++) begin
        if (tbl[i].fr == f) begin
          in_q.push_back(beat_t'{tbl[i].d, tbl[i].s, tbl[i].l});
          exp_q.push_back(beat_t'{tbl[i].ed, tbl[i].es, tbl[i].el});
          len++;
        end
      end
      drain("table", 60);
      check("table_len", 64'(frame_len), 64'(len));
      check("table_latency", 64'(first_wr - first_rd), 64'(2 * len));
      check("table_ovf", 64'(frame_ovf), 64'd0);
    end

    // Single all-ones beat: state walk LOAD, SORT, DRAIN, IDLE.
    cyc = 0;
    st_log.delete();
    first_rd = -1;
    first_wr = -1;
    in_q.push_back(beat_t'{64'hFFFF_FFFF_FFFF_FFFF, 8'hA5, 1'b1});
    exp_q.push_back(beat_t'{64'hFFFF_FFFF_FFFF_FFFF, 8'hA5, 1'b1});
    drain("single", 20);
    step();
    check("single_len", 64'(frame_len), 64'd1);
    check("single_latency", 64'(first_wr - first_rd), 64'd2);
    if (first_rd > 0 && st_log.size() >= first_rd + 3) begin
      check("single_st_load", 64'(st_log[first_rd - 1]), 64'(ST_LOAD));
      check("single_st_sort", 64'(st_log[first_rd]), 64'(ST_SORT));
      check("single_st_drain", 64'(st_log[first_rd + 1]), 64'(ST_DRAIN));
      check("single_st_idle", 64'(st_log[first_rd + 2]), 64'(ST_IDLE));
    end else begin
      check("single_st_log", 64'(st_log.size()), 64'(first_rd + 3));
    end

    // 17 beats without last: first 16 form a truncated frame, value 0 opens the next.
    for (int v = 16; v >= 0; v--) in_q.push_back(beat_t'{64'(v), 8'(v), 1'b0});
    for (int v = 1; v <= 16; v++) exp_q.push_back(beat_t'{64'(v), 8'(v), 1'(v == 16)});
    drain("ovf", 100);
    check("ovf_flag", 64'(frame_ovf), 64'd1);
    check("ovf_len", 64'(frame_len), 64'd16);
    in_q.push_back(beat_t'{64'd7, 8'h07, 1'b1});
    exp_q.push_back(beat_t'{64'd0, 8'h00, 1'b0});
    exp_q.push_back(beat_t'{64'd7, 8'h07, 1'b1});
    drain("ovf_next", 40);
    check("ovf_next_len", 64'(frame_len), 64'd2);

    // Output back-pressure: full_n low for 5 cycles after the 3rd write.
    n_wr = 0;
    first_wr = -1;
    stall_at = 3;
    stall_len = 5;
    for (int i = 0; i < 8; i++) begin
      in_q.push_back(beat_t'{64'(stall_in[i]), 8'(i + 1), 1'(i == 7)});
      exp_q.push_back(beat_t'{64'(10 * (i + 1)), 8'(stall_es[i]), 1'(i == 7)});
    end
    drain("stall", 80);
    stall_at = -1;
    check("stall_span", 64'(last_wr - first_wr), 64'd12);
    check("ovf_sticky", 64'(frame_ovf), 64'd1);

    // Reset while sorting an 8-beat frame, then a short frame must still sort.
    for (int i = 0; i < 8; i++) in_q.push_back(beat_t'{64'(8 - i), 8'(i), 1'(i == 7)});
    n = 0;
    while (current_state != ST_SORT && n < 40) begin
      step();
      n++;
    end
    check("reach_sort", 64'(current_state), 64'(ST_SORT));
    reset = 1'b1;
    #1;
    check("mid_rst_state", 64'(current_state), 64'(ST_IDLE));
    check("mid_rst_read", 64'(dout_isif_read), 64'd0);
    check("mid_rst_write", 64'(dout_osif_write), 64'd0);
    check("mid_rst_ovf", 64'(frame_ovf), 64'd0);
    step();
    check("mid_rst_hold", 64'(current_state), 64'(ST_IDLE));
    reset = 1'b0;
    in_q.delete();
    exp_q.delete();
    in_q.push_back(beat_t'{64'd2, 8'h0B, 1'b0});
    in_q.push_back(beat_t'{64'd1, 8'h0A, 1'b1});
    exp_q.push_back(beat_t'{64'd1, 8'h0A, 1'b0});
    exp_q.push_back(beat_t'{64'd2, 8'h0B, 1'b1});
    drain("post_rst", 40);
    check("post_rst_len", 64'(frame_len), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
